// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command and run-state encodings plus the
// default widths used by the CPU core, i_mem and run control.
package cpu_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_INSTR_W = 32;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic [1:0] {
      CMD_HALT = 2'd0,
      CMD_RUN  = 2'd1,
      CMD_STEP = 2'd2,
      CMD_LOAD = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host command port of the run-control sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1; cmd_op/cmd_data must be stable while cmd_valid is 1.
interface cpu_run_ctrl_if #(
   parameter int INSTR_W = cpu_pkg::DEF_INSTR_W
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [INSTR_W-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl_imem_loader.sv
// Instruction-memory loader: sequential write pointer with registered
// write strobe, address and data; rewind returns the pointer to 0.
module cpu_run_ctrl_imem_loader #(
   parameter int ADDR_W  = cpu_pkg::DEF_ADDR_W,
   parameter int INSTR_W = cpu_pkg::DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               rewind,
   input  logic [INSTR_W-1:0] data,
   output logic               we,
   output logic [ADDR_W-1:0]  addr,
   output logic [INSTR_W-1:0] wdata
);

   logic [ADDR_W-1:0] load_ptr;

   // The pointer wraps naturally at 2^ADDR_W; addr/wdata hold between writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_ptr <= '0;
         we       <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
      end else begin
         we <= load;
         if (load) begin
            addr     <= load_ptr;
            wdata    <= data;
            load_ptr <= load_ptr + 1'b1;
         end else if (rewind) begin
            load_ptr <= '0;
         end
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: HALT/RUN/STEP FSM gating the CPU clock enable,
// PC breakpoint with resume-skip, executed-cycle counter and i_mem loading.
module cpu_run_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   cpu_run_ctrl_if.slave      cmd,
   input  logic               bp_en,
   input  logic [ADDR_W-1:0]  bp_addr,
   input  logic [ADDR_W-1:0]  pc,
   output logic               cpu_ce,
   output logic               cpu_rst,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic [1:0]         state,
   output logic               bp_hit,
   output logic               cmd_err,
   output logic [CNT_W-1:0]   cyc_cnt
);

   state_e  st, st_nxt;
   cmd_op_e op;
   logic    bp_skip, bp_skip_nxt;
   logic    accept, bp_stop;
   logic    load_go, rewind_go, bp_hit_nxt, cmd_err_nxt;

   assign op            = cmd_op_e'(cmd.cmd_op);
   assign cmd.cmd_ready = (st != ST_STEP);
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   // bp_skip lets a fresh RUN execute the PC it previously stopped on.
   assign bp_stop       = bp_en && (pc == bp_addr) && !bp_skip;
   assign state         = st;

   always_comb begin
      st_nxt      = st;
      bp_skip_nxt = bp_skip;
      load_go     = 1'b0;
      rewind_go   = 1'b0;
      bp_hit_nxt  = 1'b0;
      cmd_err_nxt = 1'b0;
      cpu_ce      = 1'b0;
      case (st)
         ST_HALT: begin
            if (accept) begin
               case (op)
                  CMD_RUN: begin
                     st_nxt      = ST_RUN;
                     bp_skip_nxt = 1'b1;
                  end
                  CMD_STEP: st_nxt    = ST_STEP;
                  CMD_LOAD: load_go   = 1'b1;
                  default:  rewind_go = 1'b1;
               endcase
            end
         end
         ST_RUN: begin
            cpu_ce = !bp_stop;
            if (!bp_stop) bp_skip_nxt = 1'b0;
            if (bp_stop) begin
               st_nxt     = ST_HALT;
               bp_hit_nxt = 1'b1;
            end
            if (accept && op == CMD_HALT) st_nxt = ST_HALT;
            if (accept && op == CMD_LOAD) cmd_err_nxt = 1'b1;
         end
         ST_STEP: begin
            cpu_ce = 1'b1;
            st_nxt = ST_HALT;
         end
         default: st_nxt = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_HALT;
         bp_skip <= 1'b0;
         cpu_rst <= 1'b0;
         bp_hit  <= 1'b0;
         cmd_err <= 1'b0;
         cyc_cnt <= '0;
      end else begin
         st      <= st_nxt;
         bp_skip <= bp_skip_nxt;
         cpu_rst <= rewind_go;
         bp_hit  <= bp_hit_nxt;
         cmd_err <= cmd_err_nxt;
         if (rewind_go)
            cyc_cnt <= '0;
         else if (cpu_ce && (cyc_cnt != {CNT_W{1'b1}}))
            cyc_cnt <= cyc_cnt + 1'b1;
      end
   end

   cpu_run_ctrl_imem_loader #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_loader (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load_go),
      .rewind (rewind_go),
      .data   (cmd.cmd_data),
      .we     (imem_we),
      .addr   (imem_addr),
      .wdata  (imem_wdata)
   );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a vector table covering load/step/breakpoint/rewind,
// then hand sequences for pointer wrap, breakpoint+HALT and async reset.
module tb_cpu_run_ctrl;
   import cpu_pkg::*;

   localparam int AW = 8;
   localparam int IW = 32;
   localparam int CW = 16;

   logic          clk;
   logic          rst_n;
   logic          bp_en;
   logic [AW-1:0] bp_addr, pc;
   logic          cpu_ce, cpu_rst, imem_we, bp_hit, cmd_err;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;
   logic [1:0]    state;
   logic [CW-1:0] cyc_cnt;

   cpu_run_ctrl_if #(.INSTR_W(IW)) cmd_bus ();

   cpu_run_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd_bus.slave),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .pc         (pc),
      .cpu_ce     (cpu_ce),
      .cpu_rst    (cpu_rst),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .state      (state),
      .bp_hit     (bp_hit),
      .cmd_err    (cmd_err),
      .cyc_cnt    (cyc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [1:0]    op;
      logic [IW-1:0] data;
      logic          bpe;
      logic [AW-1:0] bpa;
      logic [AW-1:0] pc;
      logic          ce, rdy, rst, we;
      logic [AW-1:0] addr;
      logic [IW-1:0] wdata;
      logic [1:0]    st;
      logic          hit, err;
      logic [CW-1:0] cyc;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [1:0] op, input logic [IW-1:0] data,
                      input logic bpe, input logic [AW-1:0] bpa, input logic [AW-1:0] p,
                      input logic ce, input logic rdy, input logic rst, input logic we,
                      input logic [AW-1:0] addr, input logic [IW-1:0] wdata,
                      input logic [1:0] st, input logic hit, input logic err,
                      input logic [CW-1:0] cyc);
      vec_t e;
      e.v = v; e.op = op; e.data = data; e.bpe = bpe; e.bpa = bpa; e.pc = p;
      e.ce = ce; e.rdy = rdy; e.rst = rst; e.we = we; e.addr = addr; e.wdata = wdata;
      e.st = st; e.hit = hit; e.err = err; e.cyc = cyc;
      vecs.push_back(e);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic cyc_drive(input logic v, input logic [1:0] op, input logic [IW-1:0] data,
                            input logic [AW-1:0] p);
      @(posedge clk);
      #1;
      cmd_bus.cmd_valid = v;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_data  = data;
      pc                = p;
      #1;
   endtask

   task automatic chk_regs_zero(input string tag);
      chk({tag, ".state"}, 32'(state), 32'(ST_HALT));
      chk({tag, ".cpu_ce"}, 32'(cpu_ce), 32'd0);
      chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'd0);
      chk({tag, ".imem_we"}, 32'(imem_we), 32'd0);
      chk({tag, ".imem_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, ".imem_wdata"}, imem_wdata, 32'd0);
      chk({tag, ".bp_hit"}, 32'(bp_hit), 32'd0);
      chk({tag, ".cmd_err"}, 32'(cmd_err), 32'd0);
      chk({tag, ".cyc_cnt"}, 32'(cyc_cnt), 32'd0);
   endtask

   initial begin
      logic [IW-1:0] d;
      logic [AW-1:0] ea;
      rst_n             = 1'b1;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = CMD_HALT;
      cmd_bus.cmd_data  = '0;
      bp_en             = 1'b0;
      bp_addr           = '0;
      pc                = '0;

      //   v  op        data          bpe bpa    pc     ce rdy rst we addr   wdata         st hit err cyc
      add(1, CMD_LOAD, 32'h00010001, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 32'h00000000, 0, 0, 0, 16'd0);
      add(1, CMD_LOAD, 32'h00020002, 0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 32'h00010001, 0, 0, 0, 16'd0);
      add(1, CMD_LOAD, 32'h00030003, 0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h01, 32'h00020002, 0, 0, 0, 16'd0);
      add(0, CMD_HALT, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h02, 32'h00030003, 0, 0, 0, 16'd0);
      add(1, CMD_STEP, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd0);
      add(0, CMD_HALT, 32'h0,        0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h02, 32'h00030003, 2, 0, 0, 16'd0);
      add(1, CMD_STEP, 32'h0,        0, 8'h00, 8'h01, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd1);
      add(0, CMD_HALT, 32'h0,        0, 8'h00, 8'h01, 1, 0, 0, 0, 8'h02, 32'h00030003, 2, 0, 0, 16'd1);
      add(1, CMD_STEP, 32'h0,        0, 8'h00, 8'h02, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd2);
      add(1, CMD_RUN,  32'h0,        0, 8'h00, 8'h02, 1, 0, 0, 0, 8'h02, 32'h00030003, 2, 0, 0, 16'd2);
      add(0, CMD_HALT, 32'h0,        0, 8'h00, 8'h02, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd3);
      add(1, CMD_RUN,  32'h0,        1, 8'h05, 8'h00, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd3);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h00, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd3);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h01, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd4);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h02, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd5);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h03, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd6);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h04, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd7);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h05, 0, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd8);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h05, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 1, 0, 16'd8);
      add(1, CMD_RUN,  32'h0,        1, 8'h05, 8'h05, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd8);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h05, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd8);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h06, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd9);
      add(1, CMD_LOAD, 32'hDEADBEEF, 1, 8'h05, 8'h07, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd10);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h08, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 1, 16'd11);
      add(1, CMD_HALT, 32'h0,        1, 8'h05, 8'h09, 1, 1, 0, 0, 8'h02, 32'h00030003, 1, 0, 0, 16'd12);
      add(0, CMD_HALT, 32'h0,        1, 8'h05, 8'h0A, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd13);
      add(1, CMD_HALT, 32'h0,        0, 8'h00, 8'h0A, 0, 1, 0, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd13);
      add(1, CMD_LOAD, 32'h11111111, 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'h02, 32'h00030003, 0, 0, 0, 16'd0);
      add(0, CMD_HALT, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 32'h11111111, 0, 0, 0, 16'd0);
      add(0, CMD_HALT, 32'h0,        0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 32'h11111111, 0, 0, 0, 16'd0);

      // Reset values, sampled while rst_n is still low.
      #1 rst_n = 1'b0;
      #21;
      chk_regs_zero("reset");
      chk("reset.cmd_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      #1 rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         cmd_bus.cmd_valid = vecs[i].v;
         cmd_bus.cmd_op    = vecs[i].op;
         cmd_bus.cmd_data  = vecs[i].data;
         bp_en             = vecs[i].bpe;
         bp_addr           = vecs[i].bpa;
         pc                = vecs[i].pc;
         #1;
         chk($sformatf("v%0d.cpu_ce", i), 32'(cpu_ce), 32'(vecs[i].ce));
         chk($sformatf("v%0d.cmd_ready", i), 32'(cmd_bus.cmd_ready), 32'(vecs[i].rdy));
         chk($sformatf("v%0d.cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].rst));
         chk($sformatf("v%0d.imem_we", i), 32'(imem_we), 32'(vecs[i].we));
         chk($sformatf("v%0d.imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
         chk($sformatf("v%0d.imem_wdata", i), imem_wdata, vecs[i].wdata);
         chk($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
         chk($sformatf("v%0d.bp_hit", i), 32'(bp_hit), 32'(vecs[i].hit));
         chk($sformatf("v%0d.cmd_err", i), 32'(cmd_err), 32'(vecs[i].err));
         chk($sformatf("v%0d.cyc_cnt", i), 32'(cyc_cnt), 32'(vecs[i].cyc));
      end

      // Rewind, then 257 back-to-back loads: the last one wraps to address 0.
      cyc_drive(1, CMD_HALT, 32'h0, 8'h00);
      for (int i = 0; i <= 256; i++) begin
         d = 32'hA5000000 + 32'(i);
         cyc_drive(1, CMD_LOAD, d, 8'h00);
         if (i == 0) begin
            chk("wrap.cpu_rst", 32'(cpu_rst), 32'd1);
         end else begin
            ea = 8'(i - 1);
            chk($sformatf("wrap%0d.we", i - 1), 32'(imem_we), 32'd1);
            chk($sformatf("wrap%0d.addr", i - 1), 32'(imem_addr), 32'(ea));
            chk($sformatf("wrap%0d.wdata", i - 1), imem_wdata, 32'hA5000000 + 32'(i - 1));
         end
      end
      cyc_drive(0, CMD_HALT, 32'h0, 8'h00);
      chk("wrap256.we", 32'(imem_we), 32'd1);
      chk("wrap256.addr", 32'(imem_addr), 32'd0);
      chk("wrap256.wdata", imem_wdata, 32'hA5000100);
      cyc_drive(0, CMD_HALT, 32'h0, 8'h00);
      chk("wrap.we_low", 32'(imem_we), 32'd0);

      // Breakpoint and accepted HALT in the same cycle.
      bp_en   = 1'b1;
      bp_addr = 8'h03;
      cyc_drive(1, CMD_RUN, 32'h0, 8'h00);
      cyc_drive(0, CMD_HALT, 32'h0, 8'h00);
      chk("bphalt.run_ce", 32'(cpu_ce), 32'd1);
      chk("bphalt.run_state", 32'(state), 32'(ST_RUN));
      cyc_drive(1, CMD_HALT, 32'h0, 8'h03);
      chk("bphalt.ce_at_bp", 32'(cpu_ce), 32'd0);
      chk("bphalt.ready", 32'(cmd_bus.cmd_ready), 32'd1);
      cyc_drive(0, CMD_HALT, 32'h0, 8'h03);
      chk("bphalt.state", 32'(state), 32'(ST_HALT));
      chk("bphalt.bp_hit", 32'(bp_hit), 32'd1);
      cyc_drive(0, CMD_HALT, 32'h0, 8'h03);
      chk("bphalt.bp_hit_clear", 32'(bp_hit), 32'd0);

      // Asynchronous reset between edges while running.
      bp_en = 1'b0;
      cyc_drive(1, CMD_RUN, 32'h0, 8'h00);
      cyc_drive(0, CMD_HALT, 32'h0, 8'h01);
      chk("areset.pre_ce", 32'(cpu_ce), 32'd1);
      chk("areset.pre_state", 32'(state), 32'(ST_RUN));
      #2 rst_n = 1'b0;
      #1;
      chk_regs_zero("areset");
      #3 rst_n = 1'b1;
      cyc_drive(1, CMD_LOAD, 32'hCAFEF00D, 8'h02);
      chk("areset.post_state", 32'(state), 32'(ST_HALT));
      chk("areset.post_ce", 32'(cpu_ce), 32'd0);
      cyc_drive(0, CMD_HALT, 32'h0, 8'h02);
      chk("areset.load_we", 32'(imem_we), 32'd1);
      chk("areset.load_addr", 32'(imem_addr), 32'd0);
      chk("areset.load_wdata", imem_wdata, 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run-control sequencer for the 8-bit GPIO CPU.
- Loads 32-bit instruction words into instruction memory over a valid/ready command port.
- Gates the CPU register and PC update with a clock enable to give run, halt, single-step and a PC breakpoint.
- Sits between a host-side command source (UART bridge or test bench) and the CPU core/i_mem. It is the only block that drives i_mem write signals and the CPU enable.

Parameters:
- ADDR_W, 8, instruction-memory address / PC width.
- INSTR_W, 32, instruction word width.
- CNT_W, 16, width of the executed-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=LOAD
- cmd_data  in  INSTR_W  instruction word for LOAD
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint PC
- pc  in  ADDR_W  current CPU PC
- cpu_ce  out  1  CPU register/PC update enable
- cpu_rst  out  1  one-cycle synchronous PC/register clear request to CPU
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  INSTR_W  write data
- state  out  2  0=HALT, 1=RUN, 2=STEP
- bp_hit  out  1  one-cycle pulse when a breakpoint stops RUN
- cmd_err  out  1  one-cycle pulse on an illegal command
- cyc_cnt  out  CNT_W  number of cycles with cpu_ce=1

Behaviour:
- Reset (async, rst_n=0):
  - state=HALT; cpu_ce=0, cpu_rst=0, imem_we=0, imem_addr=0, imem_wdata=0, bp_hit=0, cmd_err=0, cyc_cnt=0.
  - Internal load_ptr=0, bp_skip=0.
  - Reset mid-RUN or mid-LOAD drops cpu_ce and imem_we immediately. A partial program stays in i_mem.
- Command acceptance: a command is accepted at posedge N. Its effect is visible in cycle N+1. All outputs except cpu_ce and cmd_ready are registered.
- cmd_ready is 1 in HALT and RUN, and 0 in STEP.
- HALT state:
  - RUN -> RUN, and bp_skip<=1.
  - STEP -> STEP.
  - LOAD -> in cycle N+1: imem_we=1, imem_addr=load_ptr, imem_wdata=cmd_data. load_ptr increments and wraps from 2^ADDR_W-1 to 0. State stays HALT. Back-to-back LOADs give one write per cycle.
  - HALT (rewind) -> load_ptr<=0, cyc_cnt<=0, and cpu_rst=1 for cycle N+1.
- RUN state:
  - cpu_ce = !(bp_en & pc==bp_addr & !bp_skip), combinational.
  - bp_skip clears after the first cycle with cpu_ce=1. This lets RUN resume past the PC it stopped on.
  - If bp_en & pc==bp_addr & !bp_skip: the instruction at bp_addr is not executed, state<=HALT, and bp_hit pulses in the next cycle.
  - An accepted HALT -> HALT. cpu_ce is still 1 in the acceptance cycle.
  - RUN or STEP in RUN: ignored, no error.
  - LOAD in RUN: ignored, and cmd_err pulses in cycle N+1.
- STEP state: cpu_ce=1 for exactly one cycle, then HALT. Breakpoints are ignored in STEP.
- Simultaneous breakpoint and accepted HALT: go to HALT and bp_hit still pulses.
- cpu_ce is 0 in HALT, and also 0 while rst_n=0.
- cyc_cnt increments on every posedge with cpu_ce=1 and saturates at all-ones.
- bp_en/bp_addr may change at any time and are sampled combinationally.

Decomposition:
- Shared package cpu_pkg holds:
  - cmd_op encodings CMD_HALT, CMD_RUN, CMD_STEP, CMD_LOAD;
  - state encodings ST_HALT, ST_RUN, ST_STEP;
  - ADDR_W and INSTR_W defaults shared with the cpu and i_mem.
- One natural sub-module is imem_loader: load_ptr, the registered write strobe/address/data, and rewind. The FSM, breakpoint gate and counter stay in cpu_run_ctrl.

Test Plan:
- Reset then LOAD 0x00010001, 0x00020002, 0x00030003 back-to-back -> imem_we high 3 cycles, addresses 0,1,2, data matches; state stays 0.
- From HALT, STEP ×3 with pc driven 0,1,2 -> exactly one cpu_ce cycle per STEP; cyc_cnt=3; cmd_ready=0 during each STEP cycle.
- bp_en=1, bp_addr=0x05, RUN with pc counting from 0 -> cpu_ce high at pc 0..4, low at pc=5; bp_hit pulses once; state=HALT. A second RUN executes pc=5 (cpu_ce=1) and continues.
- In RUN, issue LOAD -> cmd_err one-cycle pulse, no imem_we, state stays RUN. Then HALT -> state=HALT next cycle.
- HALT in HALT after 4 LOADs -> cpu_rst pulse 1 cycle, cyc_cnt=0; next LOAD writes imem_addr=0. Also load 256 words -> word 257 wraps to address 0.
- Assert rst_n low mid-RUN (asynchronously, between edges) -> cpu_ce falls without a clock edge; all registered outputs 0; state=HALT after release.
